iq_avg_acc_ctrl: RTL
====================

// Module: iq_avg_acc_ctrl
// PURPOSE
//  Sequencer for the IQ averaging accumulator (acc_iq_avg) datapath.
//  - Frames N input samples per accumulation window and drives clear/enable/dump to the accumulator.
//  - Hands each finished frame downstream with a valid/ack handshake.
//  - Packs a 32-bit status word that feeds the software-visible status register input (user_data_in).
//  - Single clock domain, shared with the accumulator.
// PARAMETERS
//  N_W      16  width of cfg_n_avg and sample_cnt (status packs low 16 bits)
//  FRAME_W  12  width of frame counter (wraps modulo 2^FRAME_W)
// PORTS
//  OPB_Clk         in   1        clock; all logic rising-edge
//  OPB_Rst         in   1        synchronous, active-high reset
//  cfg_start       in   1        1-cycle pulse: begin averaging
//  cfg_stop        in   1        1-cycle pulse: stop / abort
//  cfg_continuous  in   1        1 = re-arm after each frame; sampled at start
//  cfg_n_avg       in   N_W      samples per frame; sampled at start; 0 treated as 1
//  in_valid        in   1        input sample strobe from IQ datapath
//  acc_en          out  1        accumulator: add current sample
//  acc_clr         out  1        accumulator: load current sample instead of adding
//  dump_valid      out  1        frame result valid at accumulator output
//  dump_ack        in   1        downstream has taken the frame
//  busy            out  1        state != IDLE
//  status_word     out  32       to status register user_data_in
// BEHAVIOUR
//  Reset: state=IDLE; sample_cnt=0; frame_cnt=0; overflow=0; n_lat=1; cont_lat=0; all outputs 0.
//  States (2-bit): IDLE=0, ACC=1, DUMP=2; 3 unused -> IDLE.
//  IDLE:
//  - cfg_start & !cfg_stop: latch n_lat=max(cfg_n_avg,1) and cont_lat; clear overflow and sample_cnt -> ACC.
//  - start+stop in same cycle: stay IDLE. frame_cnt is cleared only by reset.
//  ACC:
//  - acc_en = in_valid & (state==ACC), combinational.
//  - acc_clr = acc_en & (sample_cnt==0), combinational; first sample loads the accumulator.
//  - Each accepted sample: sample_cnt++.
//  - On accepted sample with sample_cnt==n_lat-1: sample_cnt<=0, frame_cnt++ -> DUMP.
//  - cfg_stop (priority over in_valid same cycle): -> IDLE, partial frame discarded, no dump, sample_cnt<=0.
//  - cfg_start in ACC or DUMP: ignored.
//  DUMP:
//  - dump_valid = (state==DUMP), registered state decode. It rises 1 cycle after the last sample's acc_en,
//    which matches the accumulator's 1-cycle latency.
//  - Held until dump_ack; dump_ack while dump_valid=0 has no effect.
//  - in_valid while in DUMP: sample dropped (acc_en=0), overflow<=1 (sticky until next start).
//  - On dump_ack: if cont_lat & !stop_pend -> ACC, else -> IDLE.
//  - cfg_stop in DUMP sets stop_pend; the frame still completes. stop_pend is cleared on leaving DUMP.
//  - stop_pend and dump_ack in the same cycle: -> IDLE.
//  Frame length: n_lat=1 gives ACC->DUMP on every accepted sample; acc_clr and acc_en are both asserted for that sample.
//  busy = (state != IDLE).
//  status_word is registered, 1 cycle behind internal state:
//  - [31:30] state
//  - [29] overflow
//  - [28] cont_lat
//  - [27:16] frame_cnt (zero-extended or truncated to 12 bits)
//  - [15:0] sample_cnt
//  Reset mid-operation: immediate return to reset values; dump_valid drops without ack.
// TESTING
//  1 Reset, start n_avg=4 single-shot, 4 in_valid back-to-back -> acc_clr on sample 1 only, acc_en x4,
//    dump_valid the next cycle; held 3 cycles until ack; then IDLE, status[27:16]=1.
//  2 Continuous n_avg=3, ack immediately each frame, 9 samples with gaps -> 3 dumps;
//    frame_cnt=3; state stays ACC after the third ack.
//  3 In DUMP, withhold ack 5 cycles while in_valid=1 -> acc_en=0 throughout; status[29]=1 after ack;
//    next start clears it.
//  4 Stop after 2 of 4 samples -> IDLE next cycle, no dump_valid, sample_cnt=0, frame_cnt unchanged.
//  5 Edge cases:
//    - cfg_n_avg=0 -> every sample yields a dump.
//    - start+stop same cycle in IDLE -> stays IDLE.
//    - stop in DUMP with continuous -> IDLE after ack.
//  6 Assert OPB_Rst while dump_valid=1 -> all outputs 0 next cycle; status_word=0 the cycle after;
//    frame_cnt wraps 4095->0 when run with FRAME_W=12.

Source files
------------

// File: rtl/iq_avg_acc_ctrl.sv
// Sequencer for the IQ averaging accumulator: frames N samples per window,
// drives clear/enable to the accumulator, hands frames downstream, packs status.
module iq_avg_acc_ctrl #(
    parameter int N_W     = 16,
    parameter int FRAME_W = 12
) (
    input  logic           OPB_Clk,
    input  logic           OPB_Rst,
    input  logic           cfg_start,
    input  logic           cfg_stop,
    input  logic           cfg_continuous,
    input  logic [N_W-1:0] cfg_n_avg,
    input  logic           in_valid,
    output logic           acc_en,
    output logic           acc_clr,
    output logic           dump_valid,
    input  logic           dump_ack,
    output logic           busy,
    output logic [31:0]    status_word
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DUMP = 2'd2
    } state_t;

    localparam logic [N_W-1:0]     N_ONE = N_W'(1);
    localparam logic [FRAME_W-1:0] F_ONE = FRAME_W'(1);

    state_t             state;
    logic [N_W-1:0]     sample_cnt;
    logic [N_W-1:0]     n_lat;
    logic [FRAME_W-1:0] frame_cnt;
    logic               overflow;
    logic               cont_lat;
    logic               stop_pend;
    logic [11:0]        frame_st;
    logic [15:0]        samp_st;

    assign acc_en     = in_valid && (state == ACC);
    assign acc_clr    = acc_en && (sample_cnt == '0);
    assign dump_valid = (state == DUMP);
    assign busy       = (state != IDLE);

    // Status fields are fixed at 12/16 bits regardless of parameterisation
    if (FRAME_W >= 12) begin : g_frame_trunc
        assign frame_st = frame_cnt[11:0];
    end else begin : g_frame_ext
        assign frame_st = {{(12-FRAME_W){1'b0}}, frame_cnt};
    end
    if (N_W >= 16) begin : g_samp_trunc
        assign samp_st = sample_cnt[15:0];
    end else begin : g_samp_ext
        assign samp_st = {{(16-N_W){1'b0}}, sample_cnt};
    end

    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            state       <= IDLE;
            sample_cnt  <= '0;
            n_lat       <= N_ONE;
            frame_cnt   <= '0;
            overflow    <= 1'b0;
            cont_lat    <= 1'b0;
            stop_pend   <= 1'b0;
            status_word <= '0;
        end else begin
            status_word <= {state, overflow, cont_lat, frame_st, samp_st};
            case (state)
                IDLE: begin
                    stop_pend <= 1'b0;
                    if (cfg_start && !cfg_stop) begin
                        n_lat      <= (cfg_n_avg == '0) ? N_ONE : cfg_n_avg;
                        cont_lat   <= cfg_continuous;
                        overflow   <= 1'b0;
                        sample_cnt <= '0;
                        state      <= ACC;
                    end
                end
                ACC: begin
                    // Stop wins over a same-cycle sample; the partial frame is dropped
                    if (cfg_stop) begin
                        sample_cnt <= '0;
                        state      <= IDLE;
                    end else if (acc_en) begin
                        if (sample_cnt == n_lat - N_ONE) begin
                            sample_cnt <= '0;
                            frame_cnt  <= frame_cnt + F_ONE;
                            state      <= DUMP;
                        end else begin
                            sample_cnt <= sample_cnt + N_ONE;
                        end
                    end
                end
                DUMP: begin
                    if (in_valid)
                        overflow <= 1'b1;
                    if (dump_ack) begin
                        stop_pend <= 1'b0;
                        state     <= (cont_lat && !stop_pend && !cfg_stop) ? ACC : IDLE;
                    end else if (cfg_stop) begin
                        stop_pend <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
